// File: rtl/se_arbiter_pkg.sv
// Shared definitions for the search-engine arbiter and its round-robin picker.
package se_arbiter_pkg;

    localparam int unsigned SE_MAC_W   = 48;
    localparam int unsigned SE_HASH_W  = 10;
    localparam int unsigned SE_PMAP_W  = 16;
    localparam int unsigned TOUT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_AGING  = 2'd2
    } se_state_t;

    // Index width for an n-entry requester vector (at least one bit).
    function automatic int unsigned se_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/se_rr_pick.sv
// Round-robin picker: first eligible index at or after rr, wrapping modulo NREQ.
module se_rr_pick
    import se_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IDX_W = se_idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [IDX_W-1:0] rr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    // Scan from rr upward; the first hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!valid && eligible[(32'(rr) + k) % NREQ]) begin
                grant = IDX_W'((32'(rr) + k) % NREQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/se_arbiter.sv
// Shares one hash-engine search port among NREQ frame processors and
// inserts periodic aging requests between search transactions.
module se_arbiter
    import se_arbiter_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned AGING_PERIOD = 1000000,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      aging_en,
    input  logic [NREQ-1:0]           req_se_req,
    input  logic [SE_MAC_W*NREQ-1:0]  req_se_mac,
    input  logic [SE_HASH_W*NREQ-1:0] req_se_hash,
    input  logic [SE_PMAP_W*NREQ-1:0] req_se_portmap,
    input  logic [NREQ-1:0]           req_se_source,
    output logic [NREQ-1:0]           req_se_ack,
    output logic [NREQ-1:0]           req_se_nak,
    output logic [SE_PMAP_W-1:0]      req_se_result,
    output logic                      se_req,
    output logic [SE_MAC_W-1:0]       se_mac,
    output logic [SE_HASH_W-1:0]      se_hash,
    output logic [SE_PMAP_W-1:0]      se_portmap,
    output logic                      se_source,
    input  logic                      se_ack,
    input  logic                      se_nak,
    input  logic [SE_PMAP_W-1:0]      se_result,
    output logic                      aging_req,
    input  logic                      aging_ack,
    output logic [TOUT_CNT_W-1:0]     timeout_cnt
);

    localparam int unsigned IDX_W  = se_idx_w(NREQ);
    localparam int unsigned AGE_W  = $clog2(AGING_PERIOD + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0]  AGE_LAST  = AGE_W'(AGING_PERIOD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    se_state_t         state;
    logic [IDX_W-1:0]  rr;
    logic [IDX_W-1:0]  gnt;
    logic [IDX_W-1:0]  next_rr;
    logic [NREQ-1:0]   served;
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   gnt_onehot;
    logic [NREQ-1:0]   done_mask;
    logic [WAIT_W-1:0] wait_cnt;
    logic [AGE_W-1:0]  age_cnt;
    logic              aging_pend;
    logic              age_wrap;
    logic              aging_take;
    logic              search_done;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    assign eligible    = req_se_req & ~served;
    assign gnt_onehot  = NREQ'(1) << gnt;
    assign next_rr     = (gnt == IDX_W'(NREQ - 1)) ? '0 : gnt + IDX_W'(1);
    assign age_wrap    = aging_en && (age_cnt == AGE_LAST);
    assign aging_take  = (state == ST_IDLE) && aging_pend;
    assign search_done = (state == ST_SEARCH) && (se_ack || se_nak || (wait_cnt == WAIT_LAST));
    assign done_mask   = search_done ? gnt_onehot : '0;

    se_rr_pick #(.NREQ(NREQ)) u_pick (
        .eligible (eligible),
        .rr       (rr),
        .grant    (pick_idx),
        .valid    (pick_valid)
    );

    // Aging period timer and the sticky pending flag it raises on wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            age_cnt    <= '0;
            aging_pend <= 1'b0;
        end else begin
            if (!aging_en || age_wrap)
                age_cnt <= '0;
            else
                age_cnt <= age_cnt + AGE_W'(1);
            if (aging_take)
                aging_pend <= 1'b0;
            else if (age_wrap)
                aging_pend <= 1'b1;
        end
    end

    // Served mask: set on completion, cleared (with priority) whenever the request is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            served <= '0;
        else
            served <= (served | done_mask) & req_se_req;
    end

    // Main FSM: grant/latch, run one search or one aging request, pulse the response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            rr            <= '0;
            gnt           <= '0;
            wait_cnt      <= '0;
            se_req        <= 1'b0;
            se_mac        <= '0;
            se_hash       <= '0;
            se_portmap    <= '0;
            se_source     <= 1'b0;
            aging_req     <= 1'b0;
            req_se_ack    <= '0;
            req_se_nak    <= '0;
            req_se_result <= '0;
            timeout_cnt   <= '0;
        end else begin
            req_se_ack <= '0;
            req_se_nak <= '0;
            case (state)
                ST_IDLE: begin
                    if (aging_pend) begin
                        aging_req <= 1'b1;
                        state     <= ST_AGING;
                    end else if (pick_valid) begin
                        gnt        <= pick_idx;
                        se_mac     <= req_se_mac[32'(pick_idx)*SE_MAC_W +: SE_MAC_W];
                        se_hash    <= req_se_hash[32'(pick_idx)*SE_HASH_W +: SE_HASH_W];
                        se_portmap <= req_se_portmap[32'(pick_idx)*SE_PMAP_W +: SE_PMAP_W];
                        se_source  <= req_se_source[pick_idx];
                        se_req     <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (se_ack) begin
                        se_req        <= 1'b0;
                        req_se_ack    <= gnt_onehot;
                        req_se_result <= se_result;
                        rr            <= next_rr;
                        state         <= ST_IDLE;
                    end else if (se_nak) begin
                        se_req     <= 1'b0;
                        req_se_nak <= gnt_onehot;
                        rr         <= next_rr;
                        state      <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        se_req     <= 1'b0;
                        req_se_nak <= gnt_onehot;
                        rr         <= next_rr;
                        state      <= ST_IDLE;
                        if (timeout_cnt != '1)
                            timeout_cnt <= timeout_cnt + TOUT_CNT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_AGING: begin
                    if (aging_ack) begin
                        aging_req <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_se_arbiter.sv
// Directed bench for se_arbiter: lookup, round-robin, no-regrant, timeout, aging, reset.
module tb_se_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TOUT = 32;
    localparam int unsigned AGEP = 20;

    localparam logic [47:0] MAC0 = 48'hf0f1f2f3f4f5;
    localparam logic [47:0] MAC1 = 48'h0a0b0c0d0e0f;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             aging_en;
    logic [1:0]       req_se_req;
    logic [95:0]      req_se_mac;
    logic [19:0]      req_se_hash;
    logic [31:0]      req_se_portmap;
    logic [1:0]       req_se_source;
    logic [1:0]       req_se_ack;
    logic [1:0]       req_se_nak;
    logic [15:0]      req_se_result;
    logic             se_req;
    logic [47:0]      se_mac;
    logic [9:0]       se_hash;
    logic [15:0]      se_portmap;
    logic             se_source;
    logic             se_ack;
    logic             se_nak;
    logic [15:0]      se_result;
    logic             aging_req;
    logic             aging_ack;
    logic [15:0]      timeout_cnt;

    int checks   = 0;
    int failures = 0;

    se_arbiter #(.NREQ(NREQ), .AGING_PERIOD(AGEP), .TIMEOUT(TOUT)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .aging_en       (aging_en),
        .req_se_req     (req_se_req),
        .req_se_mac     (req_se_mac),
        .req_se_hash    (req_se_hash),
        .req_se_portmap (req_se_portmap),
        .req_se_source  (req_se_source),
        .req_se_ack     (req_se_ack),
        .req_se_nak     (req_se_nak),
        .req_se_result  (req_se_result),
        .se_req         (se_req),
        .se_mac         (se_mac),
        .se_hash        (se_hash),
        .se_portmap     (se_portmap),
        .se_source      (se_source),
        .se_ack         (se_ack),
        .se_nak         (se_nak),
        .se_result      (se_result),
        .aging_req      (aging_req),
        .aging_ack      (aging_ack),
        .timeout_cnt    (timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        aging_en       = 1'b0;
        req_se_req     = '0;
        req_se_mac     = '0;
        req_se_hash    = '0;
        req_se_portmap = '0;
        req_se_source  = '0;
        se_ack         = 1'b0;
        se_nak         = 1'b0;
        se_result      = '0;
        aging_ack      = 1'b0;

        // Reset state
        #2 rstn = 1'b0;
        #1;
        chk("rst_se_req", 64'(se_req), 64'd0);
        chk("rst_aging_req", 64'(aging_req), 64'd0);
        chk("rst_ack", 64'(req_se_ack), 64'd0);
        chk("rst_nak", 64'(req_se_nak), 64'd0);
        chk("rst_tocnt", 64'(timeout_cnt), 64'd0);
        chk("rst_result", 64'(req_se_result), 64'd0);
        chk("rst_se_mac", 64'(se_mac), 64'd0);
        tick();
        tick();
        rstn = 1'b1;

        // Requester fields
        req_se_mac[47:0]      = MAC0;
        req_se_hash[9:0]      = 10'h155;
        req_se_portmap[15:0]  = 16'h0001;
        req_se_source[0]      = 1'b0;
        req_se_mac[95:48]     = MAC1;
        req_se_hash[19:10]    = 10'h2aa;
        req_se_portmap[31:16] = 16'h0100;
        req_se_source[1]      = 1'b1;

        // 1: single destination lookup from requester 0
        req_se_req = 2'b01;
        #1;
        chk("t1_no_comb_req", 64'(se_req), 64'd0);
        tick();
        chk("t1_se_req", 64'(se_req), 64'd1);
        chk("t1_se_mac", 64'(se_mac), 64'(MAC0));
        chk("t1_se_hash", 64'(se_hash), 64'h155);
        chk("t1_se_pmap", 64'(se_portmap), 64'h0001);
        chk("t1_se_src", 64'(se_source), 64'd0);
        tick();
        tick();
        chk("t1_hold", 64'(se_req), 64'd1);
        se_ack = 1'b1;
        se_result = 16'h0002;
        tick();
        se_ack = 1'b0;
        se_result = 16'hdead;
        chk("t1_ack", 64'(req_se_ack), 64'b01);
        chk("t1_result", 64'(req_se_result), 64'h0002);
        chk("t1_se_req_drop", 64'(se_req), 64'd0);
        chk("t1_no_nak", 64'(req_se_nak), 64'd0);
        tick();
        chk("t1_ack_pulse", 64'(req_se_ack), 64'd0);
        chk("t1_result_hold", 64'(req_se_result), 64'h0002);

        // 3: requester 0 keeps req high -> no regrant until it drops
        repeat (3) tick();
        chk("t3_no_regrant", 64'(se_req), 64'd0);
        req_se_req = 2'b00;
        tick();
        req_se_req = 2'b01;
        chk("t3_still_idle", 64'(se_req), 64'd0);
        tick();
        chk("t3_regrant", 64'(se_req), 64'd1);
        se_nak = 1'b1;
        tick();
        se_nak = 1'b0;
        chk("t3_nak", 64'(req_se_nak), 64'b01);
        chk("t3_nak_no_ack", 64'(req_se_ack), 64'd0);
        chk("t3_nak_drop", 64'(se_req), 64'd0);
        req_se_req = 2'b00;
        tick();
        chk("t3_nak_pulse", 64'(req_se_nak), 64'd0);

        // 2: both requesters with rr=1 -> requester 1 first, then 0
        req_se_req = 2'b11;
        tick();
        chk("t2_g1_req", 64'(se_req), 64'd1);
        chk("t2_g1_mac", 64'(se_mac), 64'(MAC1));
        chk("t2_g1_src", 64'(se_source), 64'd1);
        chk("t2_g1_pmap", 64'(se_portmap), 64'h0100);
        se_ack = 1'b1;
        se_result = 16'h0010;
        tick();
        se_ack = 1'b0;
        chk("t2_g1_ack", 64'(req_se_ack), 64'b10);
        chk("t2_g1_res", 64'(req_se_result), 64'h0010);
        tick();
        chk("t2_g0_req", 64'(se_req), 64'd1);
        chk("t2_g0_mac", 64'(se_mac), 64'(MAC0));
        se_ack = 1'b1;
        se_nak = 1'b1;
        se_result = 16'h0004;
        tick();
        se_ack = 1'b0;
        se_nak = 1'b0;
        chk("t2_g0_ack", 64'(req_se_ack), 64'b01);
        chk("t2_g0_both_is_ack", 64'(req_se_nak), 64'd0);
        chk("t2_g0_res", 64'(req_se_result), 64'h0004);
        tick();
        chk("t2_both_masked", 64'(se_req), 64'd0);
        req_se_req = 2'b00;
        tick();

        // 4: engine never responds -> forced NAK after TOUT cycles of se_req
        req_se_req = 2'b01;
        tick();
        chk("t4_start", 64'(se_req), 64'd1);
        repeat (TOUT - 1) tick();
        chk("t4_still_req", 64'(se_req), 64'd1);
        chk("t4_no_nak_yet", 64'(req_se_nak), 64'd0);
        tick();
        chk("t4_drop", 64'(se_req), 64'd0);
        chk("t4_nak", 64'(req_se_nak), 64'b01);
        chk("t4_tocnt", 64'(timeout_cnt), 64'd1);
        req_se_req = 2'b00;
        tick();
        chk("t4_nak_pulse", 64'(req_se_nak), 64'd0);

        // 5: aging wrap during an in-flight search
        aging_en = 1'b1;
        req_se_req = 2'b11;
        tick();
        chk("t5_g1_mac", 64'(se_mac), 64'(MAC1));
        repeat (20) tick();
        chk("t5_no_aging_mid", 64'(aging_req), 64'd0);
        chk("t5_search_held", 64'(se_req), 64'd1);
        se_ack = 1'b1;
        se_result = 16'h0020;
        tick();
        se_ack = 1'b0;
        chk("t5_ack", 64'(req_se_ack), 64'b10);
        chk("t5_aging_not_yet", 64'(aging_req), 64'd0);
        tick();
        chk("t5_aging_req", 64'(aging_req), 64'd1);
        chk("t5_aging_prio", 64'(se_req), 64'd0);
        aging_en = 1'b0;
        tick();
        tick();
        chk("t5_aging_hold", 64'(aging_req), 64'd1);
        aging_ack = 1'b1;
        tick();
        aging_ack = 1'b0;
        chk("t5_aging_drop", 64'(aging_req), 64'd0);
        chk("t5_no_search_yet", 64'(se_req), 64'd0);
        tick();
        chk("t5_resume_req", 64'(se_req), 64'd1);
        chk("t5_resume_mac", 64'(se_mac), 64'(MAC0));

        // 6: asynchronous reset during SEARCH
        #2 rstn = 1'b0;
        #1;
        chk("t6_se_req", 64'(se_req), 64'd0);
        chk("t6_aging_req", 64'(aging_req), 64'd0);
        chk("t6_tocnt", 64'(timeout_cnt), 64'd0);
        chk("t6_ack", 64'(req_se_ack), 64'd0);
        chk("t6_nak", 64'(req_se_nak), 64'd0);
        chk("t6_result", 64'(req_se_result), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_rr0_req", 64'(se_req), 64'd1);
        chk("t6_rr0_mac", 64'(se_mac), 64'(MAC0));
        se_ack = 1'b1;
        se_result = 16'h0008;
        tick();
        se_ack = 1'b0;
        chk("t6_ack0", 64'(req_se_ack), 64'b01);
        tick();
        chk("t6_g1_mac", 64'(se_mac), 64'(MAC1));
        se_ack = 1'b1;
        tick();
        se_ack = 1'b0;
        chk("t6_ack1", 64'(req_se_ack), 64'b10);
        req_se_req = 2'b00;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/se_arbiter.md
Name: se_arbiter

Overview:
- Shares the single search-engine port of hash_2_bucket (lookup/learn: se_req/se_ack/se_nak/se_result) between NREQ frame_process instances.
- Schedules periodic table aging on the engine's aging_req/aging_ack port.
- Sits between the frame processors and the hash engine, so several switch pipelines can use one MAC table.
- Round-robin among requesters; aging is inserted only between search transactions.

Parameters:
NREQ, 2, number of search requesters (2..4)
AGING_PERIOD, 1000000, clk cycles between aging requests when aging_en=1
TIMEOUT, 64, cycles to wait for se_ack/se_nak before forcing a NAK

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
aging_en  in  1  enables the aging timer
req_se_req  in  NREQ  per-requester search request, level, held until ack/nak
req_se_mac  in  48*NREQ  per-requester MAC, slice i = [48i+47:48i]
req_se_hash  in  10*NREQ  per-requester hash
req_se_portmap  in  16*NREQ  per-requester source portmap
req_se_source  in  NREQ  1=learn (source lookup), 0=destination lookup
req_se_ack  out  NREQ  one-cycle ack to requester
req_se_nak  out  NREQ  one-cycle nak to requester
req_se_result  out  16  result portmap, valid with req_se_ack (shared bus)
se_req  out  1  request to hash engine
se_mac  out  48  latched MAC
se_hash  out  10  latched hash
se_portmap  out  16  latched portmap
se_source  out  1  latched learn flag
se_ack  in  1  engine ack pulse
se_nak  in  1  engine nak pulse
se_result  in  16  engine result, valid with se_ack
aging_req  out  1  aging request to engine
aging_ack  in  1  engine aging-done pulse
timeout_cnt  out  16  saturating count of forced NAKs

Behaviour:
- Reset: all outputs 0, FSM=IDLE, rr pointer=0, aging counter=0, aging_pend=0, served mask=0.
- Every request and response signal is driven from a flop; there are no combinational paths from input to output.
- FSM states: IDLE, SEARCH, AGING.
- IDLE, when aging_pend=1:
  - Go to AGING and assert aging_req on the next cycle.
  - Clear aging_pend.
  - Aging has priority over pending search requests.
- IDLE, otherwise, when any eligible req_se_req is set (req=1 and served-mask bit=0):
  - Grant the first eligible index at or after rr, wrapping modulo NREQ.
  - Latch that requester's mac/hash/portmap/source into the se_* registers.
  - Set se_req=1 on the next cycle (grant-to-se_req latency 1), go to SEARCH, clear the wait counter.
- SEARCH:
  - Hold se_req and the se_* fields stable.
  - On se_ack: the next cycle pulses req_se_ack[g] for 1 cycle with req_se_result=se_result. Same edge: se_req=0.
  - On se_nak: the next cycle pulses req_se_nak[g]. Same edge: se_req=0.
  - se_ack and se_nak together: treat as ack.
  - Wait counter reaches TIMEOUT-1 with no response: drop se_req, pulse req_se_nak[g], increment timeout_cnt (saturates at 16'hFFFF).
  - On completion (all three cases): set served-mask bit g, set rr=(g+1) mod NREQ, return to IDLE.
  - se_ack/se_nak arriving outside SEARCH are ignored.
- Served mask: bit i clears on any cycle req_se_req[i]=0. A requester must drop its request for at least one cycle before it can be granted again.
- AGING:
  - Hold aging_req=1 until aging_ack.
  - Drop aging_req on the edge after aging_ack and return to IDLE.
  - No timeout while in AGING.
- Aging timer:
  - When aging_en=1, counts 0..AGING_PERIOD-1 and wraps.
  - Wrap sets aging_pend. A repeated wrap while pend=1 does not stack.
  - aging_en=0 holds the counter at 0 and does not clear a pending request.
- req_se_result holds its last value when no ack is pulsed.
- A requester dropping its req while in SEARCH does not abort the search; the response is still pulsed.
- Asynchronous reset mid-transaction returns everything to the reset state. The engine sees se_req fall immediately.

Decomposition:
- Shared package: SE_MAC_W=48, SE_HASH_W=10, SE_PMAP_W=16, FSM state encodings.
- One natural sub-module: se_rr_pick. It is combinational; inputs are the eligible vector and rr; outputs are the grant index and a valid flag. It is reused by the egress scheduler.

Test Plan:
1. Requester 0 issues a destination lookup for mac f0f1f2f3f4f5; engine acks 3 cycles after se_req with result 16'h0002. Required: se_req 1 cycle after grant; req_se_ack[0] pulses 1 cycle after se_ack with req_se_result=0002; req_se_ack[1] stays 0.
2. Both requesters assert in the same cycle, with rr=0. Required: requester 0 granted first, then requester 1 granted after 0 completes. Repeat with rr=1 and requester 1 is granted first.
3. Requester 0 holds req high after its ack while requester 1 is idle. Required: no regrant of requester 0 until it drops req for ≥1 cycle.
4. Engine never responds. Required: req_se_nak pulses after exactly TIMEOUT cycles of se_req; timeout_cnt=1; se_req=0.
5. AGING_PERIOD=20, aging_en=1, with a search in flight at the wrap. Required: aging_req rises only after the search completes; it falls the edge after aging_ack; pending searches resume afterward.
6. Assert rstn=0 during SEARCH. Required: se_req, aging_req, all acks/naks and timeout_cnt are 0 immediately. After release, requests are arbitrated from rr=0.
